// File: rtl/aes_cbc_pkg.sv
// Shared definitions for the AES-256 CBC encrypt and decrypt chaining controllers.
//   BLK_W       : AES block width in bits
//   cbc_state_e : chaining-controller FSM state encoding
package aes_cbc_pkg;

    parameter int unsigned BLK_W = 128;

    typedef enum logic [2:0] {
        StIdle,
        StReady,
        StIssue,
        StWait,
        StOut
    } cbc_state_e;

endpackage

// File: rtl/cbc_out_buf.sv
// One-entry valid/ready holding register with a last flag.
// Ports:
//   clk_i, rst_i      : clock, asynchronous active-high reset
//   en_i              : global enable; when low the entry neither loads nor drains
//   load_i            : capture data_i/last_i (only issued while the entry is empty)
//   data_i, last_i    : incoming block and end-of-message flag
//   valid_o           : entry holds a block
//   data_o, last_o    : held block and flag, stable until drained
//   ready_i           : downstream accepts the held block
module cbc_out_buf
    import aes_cbc_pkg::*;
#(
    parameter int unsigned Width = BLK_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             load_i,
    input  logic [Width-1:0] data_i,
    input  logic             last_i,
    output logic             valid_o,
    output logic [Width-1:0] data_o,
    output logic             last_o,
    input  logic             ready_i
);

    logic             valid_q, valid_d;
    logic [Width-1:0] data_q, data_d;
    logic             last_q, last_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;
        if (en_i) begin
            if (valid_q && ready_i) begin
                valid_d = 1'b0;
            end
            if (load_i) begin
                valid_d = 1'b1;
                data_d  = data_i;
                last_d  = last_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign last_o  = last_q;

endmodule

// File: rtl/aes256_cbc_enc_ctrl.sv
// AES-256 CBC encryption chaining controller.
// Latches an IV, XORs each plaintext block with the chaining value, hands the result to an
// external AES core over valid/ready, and returns the ciphertext through a one-entry buffer.
// Ports:
//   clk, resetn (active-high async reset), enable_i (global freeze)
//   ivalid_i/iv_i                      : IV load
//   pvalid_i/p_i/plast_i/pready_o      : plaintext input stream
//   core_valid_o/core_blk_o/core_ready_i : block to AES core
//   core_done_i/core_c_i               : AES core result pulse
//   cvalid_o/c_o/clast_o/cready_i      : ciphertext output stream
//   busy_o, err_o (sticky), count_o    : status
module aes256_cbc_enc_ctrl #(
    parameter int unsigned BLK_W = 128,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             enable_i,
    input  logic             ivalid_i,
    input  logic [BLK_W-1:0] iv_i,
    input  logic             pvalid_i,
    input  logic [BLK_W-1:0] p_i,
    input  logic             plast_i,
    output logic             pready_o,
    output logic             core_valid_o,
    output logic [BLK_W-1:0] core_blk_o,
    input  logic             core_ready_i,
    input  logic             core_done_i,
    input  logic [BLK_W-1:0] core_c_i,
    output logic             cvalid_o,
    output logic [BLK_W-1:0] c_o,
    output logic             clast_o,
    input  logic             cready_i,
    output logic             busy_o,
    output logic             err_o,
    output logic [CNT_W-1:0] count_o
);

    import aes_cbc_pkg::*;

    cbc_state_e       state_q, state_d;
    logic [BLK_W-1:0] chain_q, chain_d;
    logic [BLK_W-1:0] blk_q, blk_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;

    logic             buf_valid;
    logic             buf_load;
    logic             p_fire;
    logic [BLK_W-1:0] chain_eff;

    assign buf_load = enable_i && (state_q == StWait) && core_done_i;
    assign p_fire   = enable_i && pvalid_i && pready_o;
    // An IV reload in READY takes effect in the same cycle a block is accepted.
    assign chain_eff = (state_q == StReady && ivalid_i) ? iv_i : chain_q;

    // State register.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state_q <= StIdle;
            chain_q <= '0;
            blk_q   <= '0;
            last_q  <= 1'b0;
            count_q <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            chain_q <= chain_d;
            blk_q   <= blk_d;
            last_q  <= last_d;
            count_q <= count_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    // Next-state and datapath.
    always_comb begin
        state_d = state_q;
        chain_d = chain_q;
        blk_d   = blk_q;
        last_d  = last_q;
        count_d = count_q;
        busy_d  = busy_q;
        err_d   = err_q;
        if (enable_i) begin
            if (core_done_i && state_q != StWait) begin
                err_d = 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    if (ivalid_i) begin
                        chain_d = iv_i;
                        count_d = '0;
                        busy_d  = 1'b1;
                        state_d = StReady;
                    end
                end
                StReady: begin
                    if (ivalid_i) begin
                        chain_d = iv_i;
                        count_d = '0;
                    end
                    if (p_fire) begin
                        blk_d   = p_i ^ chain_eff;
                        last_d  = plast_i;
                        state_d = StIssue;
                    end
                end
                StIssue: begin
                    if (ivalid_i) err_d = 1'b1;
                    if (core_ready_i) state_d = StWait;
                end
                StWait: begin
                    if (ivalid_i) err_d = 1'b1;
                    if (core_done_i) begin
                        chain_d = core_c_i;
                        count_d = count_q + CNT_W'(1);
                        state_d = StOut;
                    end
                end
                StOut: begin
                    if (ivalid_i) err_d = 1'b1;
                    if (buf_valid && cready_i) begin
                        if (last_q) begin
                            busy_d  = 1'b0;
                            state_d = StIdle;
                        end else begin
                            state_d = StReady;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Outputs.
    always_comb begin
        pready_o     = (state_q == StReady) && !buf_valid;
        core_valid_o = (state_q == StIssue);
    end

    assign core_blk_o = blk_q;
    assign busy_o     = busy_q;
    assign err_o      = err_q;
    assign count_o    = count_q;
    assign cvalid_o   = buf_valid;

    cbc_out_buf #(
        .Width (BLK_W)
    ) u_out_buf (
        .clk_i   (clk),
        .rst_i   (resetn),
        .en_i    (enable_i),
        .load_i  (buf_load),
        .data_i  (core_c_i),
        .last_i  (last_q),
        .valid_o (buf_valid),
        .data_o  (c_o),
        .last_o  (clast_o),
        .ready_i (cready_i)
    );

endmodule

// File: tb/tb_aes256_cbc_enc_ctrl.sv
module tb_aes256_cbc_enc_ctrl;

    localparam int unsigned BLK_W = 128;
    localparam int unsigned CNT_W = 16;

    localparam logic [BLK_W-1:0] IV1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [BLK_W-1:0] P1   = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [BLK_W-1:0] X1   = 128'h6bc0bce12a459991e134741a7f9e1925;
    localparam logic [BLK_W-1:0] C1   = 128'hf58c4c04d6e5f1ba779eabfb5f7bfbd6;
    localparam logic [BLK_W-1:0] P2   = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [BLK_W-1:0] X2   = 128'h5ba1c653c8e65d26e929c4571ad47587;
    localparam logic [BLK_W-1:0] C2   = 128'h9cfc4e967edb808d679f777bc6702c7d;
    localparam logic [BLK_W-1:0] IV3  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [BLK_W-1:0] JUNK = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;
    localparam logic [BLK_W-1:0] IVX  = 128'h0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f;

    logic             clk = 1'b0;
    logic             resetn;
    logic             enable_i;
    logic             ivalid_i;
    logic [BLK_W-1:0] iv_i;
    logic             pvalid_i;
    logic [BLK_W-1:0] p_i;
    logic             plast_i;
    logic             pready_o;
    logic             core_valid_o;
    logic [BLK_W-1:0] core_blk_o;
    logic             core_ready_i;
    logic             core_done_i;
    logic [BLK_W-1:0] core_c_i;
    logic             cvalid_o;
    logic [BLK_W-1:0] c_o;
    logic             clast_o;
    logic             cready_i;
    logic             busy_o;
    logic             err_o;
    logic [CNT_W-1:0] count_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    aes256_cbc_enc_ctrl #(
        .BLK_W (BLK_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .enable_i     (enable_i),
        .ivalid_i     (ivalid_i),
        .iv_i         (iv_i),
        .pvalid_i     (pvalid_i),
        .p_i          (p_i),
        .plast_i      (plast_i),
        .pready_o     (pready_o),
        .core_valid_o (core_valid_o),
        .core_blk_o   (core_blk_o),
        .core_ready_i (core_ready_i),
        .core_done_i  (core_done_i),
        .core_c_i     (core_c_i),
        .cvalid_o     (cvalid_o),
        .c_o          (c_o),
        .clast_o      (clast_o),
        .cready_i     (cready_i),
        .busy_o       (busy_o),
        .err_o        (err_o),
        .count_o      (count_o)
    );

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b1;
        enable_i = 1'b1; ivalid_i = 1'b0; iv_i = '0;
        pvalid_i = 1'b0; p_i = '0; plast_i = 1'b0;
        core_ready_i = 1'b0; core_done_i = 1'b0; core_c_i = '0; cready_i = 1'b0;
        tick();
        resetn = 1'b0;
        tick();
    endtask

    task automatic load_iv(input logic [BLK_W-1:0] iv);
        ivalid_i = 1'b1; iv_i = iv;
        tick();
        ivalid_i = 1'b0;
    endtask

    task automatic send_p(input logic [BLK_W-1:0] p, input logic last);
        int waited = 0;
        while (!pready_o && waited < 50) begin
            tick();
            waited++;
        end
        if (!pready_o) begin
            n_tests++; n_fail++;
            $display("FAIL send_p_timeout: pready_o=%b required 1", pready_o);
        end
        pvalid_i = 1'b1; p_i = p; plast_i = last;
        tick();
        pvalid_i = 1'b0; plast_i = 1'b0;
    endtask

    task automatic core_accept();
        core_ready_i = 1'b1;
        tick();
        core_ready_i = 1'b0;
    endtask

    task automatic core_return(input logic [BLK_W-1:0] c);
        core_done_i = 1'b1; core_c_i = c;
        tick();
        core_done_i = 1'b0;
    endtask

    task automatic take_out();
        cready_i = 1'b1;
        tick();
        cready_i = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if ({cvalid_o, pready_o, core_valid_o, busy_o, err_o, clast_o} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got cv=%b pr=%b corev=%b busy=%b err=%b clast=%b required 0",
                     cvalid_o, pready_o, core_valid_o, busy_o, err_o, clast_o);
        end
        n_tests++;
        if (count_o !== 16'd0 || c_o !== '0) begin
            n_fail++;
            $display("FAIL reset_data: count=%0d c=%h required 0", count_o, c_o);
        end
        // Plaintext before an IV must not be taken and must not raise an error.
        pvalid_i = 1'b1; p_i = P1;
        tick(); tick();
        pvalid_i = 1'b0;
        n_tests++;
        if (core_valid_o !== 1'b0 || err_o !== 1'b0 || pready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL p_before_iv: corev=%b err=%b pready=%b required 0 0 0",
                     core_valid_o, err_o, pready_o);
        end
    endtask

    task automatic test_block1();
        load_iv(IV1);
        n_tests++;
        if (busy_o !== 1'b1 || pready_o !== 1'b1 || count_o !== 16'd0) begin
            n_fail++;
            $display("FAIL iv_load: busy=%b pready=%b count=%0d required 1 1 0",
                     busy_o, pready_o, count_o);
        end
        send_p(P1, 1'b0);
        n_tests++;
        if (core_valid_o !== 1'b1 || core_blk_o !== X1) begin
            n_fail++;
            $display("FAIL blk1_xor: corev=%b blk=%h required 1 %h", core_valid_o, core_blk_o, X1);
        end
        core_accept();
        n_tests++;
        if (core_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL blk1_handshake: corev=%b required 0", core_valid_o);
        end
        core_return(C1);
        n_tests++;
        if (cvalid_o !== 1'b1 || c_o !== C1 || clast_o !== 1'b0 || count_o !== 16'd1) begin
            n_fail++;
            $display("FAIL blk1_out: cv=%b c=%h clast=%b count=%0d required 1 %h 0 1",
                     cvalid_o, c_o, clast_o, count_o, C1);
        end
        take_out();
        n_tests++;
        if (cvalid_o !== 1'b0 || pready_o !== 1'b1 || busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL blk1_drain: cv=%b pready=%b busy=%b required 0 1 1",
                     cvalid_o, pready_o, busy_o);
        end
    endtask

    task automatic test_chaining();
        send_p(P2, 1'b1);
        n_tests++;
        if (core_blk_o !== X2) begin
            n_fail++;
            $display("FAIL blk2_chain: blk=%h required %h", core_blk_o, X2);
        end
        core_accept();
        core_return(C2);
        n_tests++;
        if (c_o !== C2 || clast_o !== 1'b1 || busy_o !== 1'b1 || count_o !== 16'd2) begin
            n_fail++;
            $display("FAIL blk2_out: c=%h clast=%b busy=%b count=%0d required %h 1 1 2",
                     c_o, clast_o, busy_o, count_o, C2);
        end
        take_out();
        n_tests++;
        if (busy_o !== 1'b0 || cvalid_o !== 1'b0 || pready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL blk2_idle: busy=%b cv=%b pready=%b required 0 0 0",
                     busy_o, cvalid_o, pready_o);
        end
    endtask

    task automatic test_backpressure();
        int bad_blk = 0;
        int bad_out = 0;
        do_reset();
        load_iv(IV1);
        send_p(P1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            if (core_valid_o !== 1'b1 || core_blk_o !== X1) bad_blk++;
        end
        n_tests++;
        if (bad_blk != 0) begin
            n_fail++;
            $display("FAIL core_stall: %0d unstable cycles, blk=%h required %h", bad_blk,
                     core_blk_o, X1);
        end
        core_accept();
        core_return(C1);
        for (int i = 0; i < 10; i++) begin
            tick();
            if (cvalid_o !== 1'b1 || c_o !== C1 || pready_o !== 1'b0) bad_out++;
        end
        n_tests++;
        if (bad_out != 0) begin
            n_fail++;
            $display("FAIL out_stall: %0d bad cycles, c=%h pready=%b required %h 0", bad_out,
                     c_o, pready_o, C1);
        end
        take_out();
        send_p(P2, 1'b0);
        n_tests++;
        if (core_blk_o !== X2) begin
            n_fail++;
            $display("FAIL bp_chain: blk=%h required %h", core_blk_o, X2);
        end
    endtask

    task automatic test_errors();
        do_reset();
        load_iv(IV3);
        core_return(JUNK);  // done pulse in READY
        n_tests++;
        if (err_o !== 1'b1 || cvalid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL done_in_ready: err=%b cv=%b required 1 0", err_o, cvalid_o);
        end
        send_p('0, 1'b0);
        n_tests++;
        if (core_blk_o !== IV3) begin
            n_fail++;
            $display("FAIL chain_kept: blk=%h required %h", core_blk_o, IV3);
        end
        do_reset();
        load_iv(IV1);
        send_p('0, 1'b0);
        core_accept();
        load_iv(IVX);       // IV strobe in WAIT
        n_tests++;
        if (err_o !== 1'b1) begin
            n_fail++;
            $display("FAIL iv_in_wait: err=%b required 1", err_o);
        end
        core_return(C2);
        take_out();
        send_p('0, 1'b0);
        n_tests++;
        if (core_blk_o !== C2) begin
            n_fail++;
            $display("FAIL chain_from_core: blk=%h required %h", core_blk_o, C2);
        end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        load_iv(IV1);
        send_p(P1, 1'b0);
        core_accept();
        resetn = 1'b1;
        tick();
        resetn = 1'b0;
        n_tests++;
        if (busy_o !== 1'b0 || core_valid_o !== 1'b0 || cvalid_o !== 1'b0 || err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: busy=%b corev=%b cv=%b err=%b required 0",
                     busy_o, core_valid_o, cvalid_o, err_o);
        end
        load_iv(IV3);
        send_p('0, 1'b0);
        n_tests++;
        if (core_blk_o !== IV3 || count_o !== 16'd0) begin
            n_fail++;
            $display("FAIL new_iv: blk=%h count=%0d required %h 0", core_blk_o, count_o, IV3);
        end
        core_accept();
        core_return(C1);
        n_tests++;
        if (count_o !== 16'd1 || c_o !== C1) begin
            n_fail++;
            $display("FAIL new_iv_out: count=%0d c=%h required 1 %h", count_o, c_o, C1);
        end
        take_out();
    endtask

    task automatic test_enable();
        int bad = 0;
        do_reset();
        load_iv(IV1);
        send_p(P1, 1'b0);
        enable_i = 1'b0;
        core_ready_i = 1'b1;
        ivalid_i = 1'b1; iv_i = IVX;  // frozen: must neither reload nor flag
        for (int i = 0; i < 3; i++) begin
            tick();
            if (core_valid_o !== 1'b1 || core_blk_o !== X1 || err_o !== 1'b0) bad++;
        end
        ivalid_i = 1'b0;
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL enable_freeze: %0d bad cycles, corev=%b blk=%h err=%b required 1 %h 0",
                     bad, core_valid_o, core_blk_o, err_o, X1);
        end
        enable_i = 1'b1;
        tick();
        core_ready_i = 1'b0;
        n_tests++;
        if (core_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL enable_resume: corev=%b required 0", core_valid_o);
        end
        core_return(C1);
        n_tests++;
        if (cvalid_o !== 1'b1 || c_o !== C1 || count_o !== 16'd1 || err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL enable_out: cv=%b c=%h count=%0d err=%b required 1 %h 1 0",
                     cvalid_o, c_o, count_o, err_o, C1);
        end
        take_out();
    endtask

    initial begin
        test_reset();
        test_block1();
        test_chaining();
        test_backpressure();
        test_errors();
        test_reset_mid_wait();
        test_enable();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
